decode_execute_unit: RTL and testbench

Combined decode/execute slice of the multi-cycle RISC datapath. It decodes `instruction_type`/`opcode` into datapath control signals and extends the 14-bit immediate. It selects the second ALU operand, computes the 32-bit ALU result, and latches the result and the zero/compare flag on the execute strobe. It sits between the register file / IR field split and the memory / write-back stages.

---
 rtl/decode_execute_unit.sv | 169 ++++++++++++++++
 tb/tb_decode_execute_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/decode_execute_unit.sv
// Decode/execute slice: instruction decode, immediate extension, operand-2 select,
// 32-bit ALU, and the execute-strobed result/flag registers.
module decode_execute_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_en,
    input  logic [1:0]  instruction_type,
    input  logic [4:0]  opcode,
    input  logic [13:0] immediate,
    input  logic [4:0]  shamt,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        reg_b,
    output logic        reg_write,
    output logic        ext_op,
    output logic [1:0]  alu_src,
    output logic [2:0]  alu_op,
    output logic        mem_read,
    output logic        mem_write,
    output logic        wb_src,
    output logic [31:0] extended_immediate,
    output logic [31:0] alu_out,
    output logic [31:0] alu_result,
    output logic        zero_signal
);

    localparam logic [1:0] TYPE_R = 2'b00;
    localparam logic [1:0] TYPE_I = 2'b01;
    localparam logic [1:0] TYPE_J = 2'b10;
    localparam logic [1:0] TYPE_S = 2'b11;

    localparam logic [1:0] SRC_IMM   = 2'b00;
    localparam logic [1:0] SRC_B     = 2'b01;
    localparam logic [1:0] SRC_SHAMT = 2'b10;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_SLL = 3'b011;
    localparam logic [2:0] OP_SLR = 3'b100;

    logic        is_cmp;
    logic        is_beq;
    logic [31:0] ext_w;
    logic [31:0] op2;
    logic [31:0] alu_result_d, alu_result_q;
    logic        zero_signal_d, zero_signal_q;

    // Unlisted type/opcode combinations fall through to the defaults: ADD on b, no enables.
    always_comb begin
        reg_b     = 1'b0;
        reg_write = 1'b0;
        ext_op    = 1'b1;
        alu_src   = SRC_B;
        alu_op    = OP_ADD;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        wb_src    = 1'b0;
        is_cmp    = 1'b0;
        is_beq    = 1'b0;
        case (instruction_type)
            TYPE_R: begin
                case (opcode)
                    5'd0: begin alu_op = OP_AND; reg_write = 1'b1; end
                    5'd1: begin alu_op = OP_ADD; reg_write = 1'b1; end
                    5'd2: begin alu_op = OP_SUB; reg_write = 1'b1; end
                    5'd3: begin alu_op = OP_SUB; is_cmp = 1'b1; end
                    default: ;
                endcase
            end
            TYPE_I: begin
                case (opcode)
                    5'd0: begin
                        alu_op    = OP_AND;
                        alu_src   = SRC_IMM;
                        ext_op    = 1'b0;
                        reg_write = 1'b1;
                    end
                    5'd1: begin
                        alu_src   = SRC_IMM;
                        reg_write = 1'b1;
                    end
                    5'd2: begin
                        alu_src   = SRC_IMM;
                        mem_read  = 1'b1;
                        wb_src    = 1'b1;
                        reg_write = 1'b1;
                    end
                    5'd3: begin
                        alu_src   = SRC_IMM;
                        mem_write = 1'b1;
                        reg_b     = 1'b1;
                    end
                    5'd4: begin
                        alu_op = OP_SUB;
                        reg_b  = 1'b1;
                        is_beq = 1'b1;
                    end
                    default: ;
                endcase
            end
            TYPE_J: ;
            TYPE_S: begin
                case (opcode)
                    5'd0: begin alu_op = OP_SLL; alu_src = SRC_SHAMT; reg_write = 1'b1; end
                    5'd1: begin alu_op = OP_SLR; alu_src = SRC_SHAMT; reg_write = 1'b1; end
                    5'd2: begin alu_op = OP_SLL; reg_write = 1'b1; end
                    5'd3: begin alu_op = OP_SLR; reg_write = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign ext_w[13:0] = immediate;
    for (genvar gi = 14; gi < 32; gi++) begin : g_ext
        assign ext_w[gi] = ext_op & immediate[13];
    end
    assign extended_immediate = ext_w;

    always_comb begin
        case (alu_src)
            SRC_IMM:   op2 = ext_w;
            SRC_B:     op2 = b;
            SRC_SHAMT: op2 = {27'b0, shamt};
            default:   op2 = 32'b0;
        endcase
    end

    always_comb begin
        case (alu_op)
            OP_ADD:  alu_out = a + op2;
            OP_SUB:  alu_out = a - op2;
            OP_AND:  alu_out = a & op2;
            OP_SLL:  alu_out = a << op2[4:0];
            OP_SLR:  alu_out = a >> op2[4:0];
            default: alu_out = 32'b0;
        endcase
    end

    // The flag only tracks CMP (signed less-than via the sign of a-b) and BEQ.
    always_comb begin
        alu_result_d  = alu_result_q;
        zero_signal_d = zero_signal_q;
        if (ex_en) begin
            alu_result_d = alu_out;
            if (is_cmp) begin
                zero_signal_d = alu_out[31];
            end else if (is_beq) begin
                zero_signal_d = (alu_out == 32'b0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_result_q  <= 32'b0;
            zero_signal_q <= 1'b0;
        end else begin
            alu_result_q  <= alu_result_d;
            zero_signal_q <= zero_signal_d;
        end
    end

    assign alu_result  = alu_result_q;
    assign zero_signal = zero_signal_q;

endmodule

// File: tb/tb_decode_execute_unit.sv
// Bench for decode_execute_unit: directed plan steps followed by random
// instructions, all compared against an instruction-level reference model.
module tb_decode_execute_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_en;
    logic [1:0]  instruction_type;
    logic [4:0]  opcode;
    logic [13:0] immediate;
    logic [4:0]  shamt;
    logic [31:0] a;
    logic [31:0] b;
    logic        reg_b, reg_write, ext_op, mem_read, mem_write, wb_src, zero_signal;
    logic [1:0]  alu_src;
    logic [2:0]  alu_op;
    logic [31:0] extended_immediate, alu_out, alu_result;

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    // Expected decode/datapath values for the instruction currently on the inputs
    logic        e_reg_b, e_reg_write, e_ext_op, e_mem_read, e_mem_write, e_wb_src;
    logic [1:0]  e_alu_src;
    logic [2:0]  e_alu_op;
    logic [31:0] e_ext, e_out;
    int          e_flag_kind;  // 0 none, 1 signed less-than, 2 equal
    logic [31:0] m_result;
    logic        m_zero;

    decode_execute_unit dut (
        .clk(clk), .reset(reset), .ex_en(ex_en),
        .instruction_type(instruction_type), .opcode(opcode),
        .immediate(immediate), .shamt(shamt), .a(a), .b(b),
        .reg_b(reg_b), .reg_write(reg_write), .ext_op(ext_op),
        .alu_src(alu_src), .alu_op(alu_op), .mem_read(mem_read),
        .mem_write(mem_write), .wb_src(wb_src),
        .extended_immediate(extended_immediate), .alu_out(alu_out),
        .alu_result(alu_result), .zero_signal(zero_signal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Instruction semantics written directly: mnemonic -> effect on a, b, imm, shamt.
    task automatic model();
        logic [31:0] sx, zx, sub;
        sx  = {{18{immediate[13]}}, immediate};
        zx  = {18'b0, immediate};
        sub = a - b;
        e_reg_b = 0; e_reg_write = 0; e_ext_op = 1; e_mem_read = 0;
        e_mem_write = 0; e_wb_src = 0; e_alu_src = 2'd1; e_alu_op = 3'd0;
        e_out = a + b; e_flag_kind = 0;
        if (instruction_type == 2'd0 && opcode == 5'd0) begin
            e_out = a & b; e_alu_op = 3'd2; e_reg_write = 1;
        end else if (instruction_type == 2'd0 && opcode == 5'd1) begin
            e_reg_write = 1;
        end else if (instruction_type == 2'd0 && opcode == 5'd2) begin
            e_out = sub; e_alu_op = 3'd1; e_reg_write = 1;
        end else if (instruction_type == 2'd0 && opcode == 5'd3) begin
            e_out = sub; e_alu_op = 3'd1; e_flag_kind = 1;
        end else if (instruction_type == 2'd1 && opcode == 5'd0) begin
            e_out = a & zx; e_alu_src = 2'd0; e_ext_op = 0; e_alu_op = 3'd2; e_reg_write = 1;
        end else if (instruction_type == 2'd1 && opcode == 5'd1) begin
            e_out = a + sx; e_alu_src = 2'd0; e_reg_write = 1;
        end else if (instruction_type == 2'd1 && opcode == 5'd2) begin
            e_out = a + sx; e_alu_src = 2'd0; e_mem_read = 1; e_wb_src = 1; e_reg_write = 1;
        end else if (instruction_type == 2'd1 && opcode == 5'd3) begin
            e_out = a + sx; e_alu_src = 2'd0; e_mem_write = 1; e_reg_b = 1;
        end else if (instruction_type == 2'd1 && opcode == 5'd4) begin
            e_out = sub; e_alu_op = 3'd1; e_reg_b = 1; e_flag_kind = 2;
        end else if (instruction_type == 2'd3 && opcode == 5'd0) begin
            e_out = a << shamt; e_alu_src = 2'd2; e_alu_op = 3'd3; e_reg_write = 1;
        end else if (instruction_type == 2'd3 && opcode == 5'd1) begin
            e_out = a >> shamt; e_alu_src = 2'd2; e_alu_op = 3'd4; e_reg_write = 1;
        end else if (instruction_type == 2'd3 && opcode == 5'd2) begin
            e_out = a << (b % 32); e_alu_op = 3'd3; e_reg_write = 1;
        end else if (instruction_type == 2'd3 && opcode == 5'd3) begin
            e_out = a >> (b % 32); e_alu_op = 3'd4; e_reg_write = 1;
        end
        e_ext = e_ext_op ? sx : zx;
    endtask

    // One instruction: drive after the falling edge, check decode, then registers after the edge.
    task automatic step(input logic [1:0] t, input logic [4:0] op, input logic [13:0] imm,
                        input logic [4:0] sh, input logic [31:0] av, input logic [31:0] bv,
                        input logic en, input logic rst);
        @(negedge clk);
        instruction_type = t; opcode = op; immediate = imm; shamt = sh;
        a = av; b = bv; ex_en = en; reset = rst;
        #1;
        model();
        check("reg_b", reg_b, e_reg_b);
        check("reg_write", reg_write, e_reg_write);
        check("ext_op", ext_op, e_ext_op);
        check("alu_src", alu_src, e_alu_src);
        check("alu_op", alu_op, e_alu_op);
        check("mem_read", mem_read, e_mem_read);
        check("mem_write", mem_write, e_mem_write);
        check("wb_src", wb_src, e_wb_src);
        check("extended_immediate", extended_immediate, e_ext);
        check("alu_out", alu_out, e_out);
        if (rst) begin
            m_result = 0; m_zero = 0;
        end else if (en) begin
            m_result = e_out;
            if (e_flag_kind == 1) m_zero = (av - bv) >> 31 != 0;
            if (e_flag_kind == 2) m_zero = (av == bv);
        end
        @(posedge clk);
        #1;
        check("alu_result", alu_result, m_result);
        check("zero_signal", zero_signal, m_zero);
        n_txn++;
        $display("txn %0d type=%0d op=%0d en=%0d rst=%0d a=%h b=%h res=%h zero=%0d",
                 n_txn, t, op, en, rst, av, bv, alu_result, zero_signal);
    endtask

    initial begin
        reset = 1; ex_en = 0; instruction_type = 0; opcode = 0;
        immediate = 0; shamt = 0; a = 0; b = 0;
        m_result = 0; m_zero = 0;

        // Reset has priority over an active ADD
        step(2'd0, 5'd1, 14'd0, 5'd0, 32'd5, 32'd3, 1'b1, 1'b1);
        check("reset_result", alu_result, 32'd0);
        check("reset_zero", zero_signal, 1'b0);

        step(2'd0, 5'd1, 14'd0, 5'd0, 32'd7, 32'd3, 1'b1, 1'b0);
        check("add_result", alu_result, 32'd10);
        check("add_reg_write", reg_write, 1'b1);
        check("add_alu_src", alu_src, 2'b01);
        step(2'd0, 5'd2, 14'd0, 5'd0, 32'd7, 32'd3, 1'b1, 1'b0);
        check("sub_result", alu_result, 32'd4);

        step(2'd0, 5'd3, 14'd0, 5'd0, 32'd2, 32'd5, 1'b1, 1'b0);
        check("cmp_lt_zero", zero_signal, 1'b1);
        check("cmp_reg_write", reg_write, 1'b0);
        step(2'd0, 5'd3, 14'd0, 5'd0, 32'd5, 32'd2, 1'b1, 1'b0);
        check("cmp_ge_zero", zero_signal, 1'b0);

        step(2'd1, 5'd4, 14'd0, 5'd0, 32'h1234, 32'h1234, 1'b1, 1'b0);
        check("beq_zero", zero_signal, 1'b1);
        check("beq_reg_b", reg_b, 1'b1);
        step(2'd0, 5'd1, 14'd0, 5'd0, 32'd9, 32'd1, 1'b1, 1'b0);
        check("add_keeps_zero", zero_signal, 1'b1);

        step(2'd1, 5'd1, 14'h3FFF, 5'd0, 32'd1, 32'd0, 1'b1, 1'b0);
        check("addi_ext", extended_immediate, 32'hFFFF_FFFF);
        check("addi_result", alu_result, 32'd0);
        step(2'd1, 5'd0, 14'h3FFF, 5'd0, 32'd1, 32'd0, 1'b1, 1'b0);
        check("andi_ext", extended_immediate, 32'h0000_3FFF);
        check("andi_ext_op", ext_op, 1'b0);
        step(2'd1, 5'd2, 14'h3FFF, 5'd0, 32'd1, 32'd0, 1'b1, 1'b0);
        check("lw_mem_read", mem_read, 1'b1);
        check("lw_wb_src", wb_src, 1'b1);
        step(2'd1, 5'd3, 14'h3FFF, 5'd0, 32'd1, 32'd0, 1'b1, 1'b0);
        check("sw_mem_write", mem_write, 1'b1);
        check("sw_reg_write", reg_write, 1'b0);

        step(2'd3, 5'd0, 14'd0, 5'd31, 32'd1, 32'd0, 1'b1, 1'b0);
        check("sll_result", alu_result, 32'h8000_0000);
        step(2'd3, 5'd3, 14'd0, 5'd0, 32'h8000_0000, 32'h24, 1'b1, 1'b0);
        check("slrv_result", alu_result, 32'h0800_0000);

        step(2'd2, 5'd1, 14'd0, 5'd0, 32'd3, 32'd4, 1'b0, 1'b0);
        check("j_enables", {reg_write, mem_read, mem_write, reg_b, wb_src}, 5'b0);
        step(2'd1, 5'd7, 14'd0, 5'd0, 32'd3, 32'd4, 1'b0, 1'b0);
        check("undef_enables", {reg_write, mem_read, mem_write, reg_b, wb_src}, 5'b0);
        check("hold_result", alu_result, 32'h0800_0000);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            step(2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 14'($urandom),
                 5'($urandom), ra, rb, $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
